// File: rtl/mem_port_arbiter_if.sv
// Bundles the I-cache, D-cache and pmem line interfaces seen by mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the caches/pmem environment.
interface mem_port_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises I-side line reads and D-side line reads/writes onto one pmem port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants between sides under contention.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic               arb_busy_o
);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

  state_t state;
  logic   d_req;
  logic   grant_d;
  logic   grant_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // On contention the side that did not win last time gets the port.
  always_comb begin
    d_req   = bus.d_read | bus.d_write;
    grant_d = d_req & ~(bus.i_read & last_d);
    grant_i = bus.i_read & ~grant_d;
  end
`else
  always_comb begin
    d_req   = bus.d_read | bus.d_write;
    grant_d = d_req;
    grant_i = bus.i_read & ~grant_d;
  end
`endif

  // NOTE: reset is sampled inside the clocked block (synchronous); every
  // register, including the wide rdata lines, is cleared so outputs read 0.
  // NOTE: all state uses non-blocking assignments so the case arms see the
  // pre-edge values of every register regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      arb_busy_o     <= 1'b0;
      bus.pmem_read  <= 1'b0;
      bus.pmem_write <= 1'b0;
      bus.pmem_addr  <= '0;
      bus.pmem_wdata <= '0;
      bus.i_resp     <= 1'b0;
      bus.d_resp     <= 1'b0;
      bus.i_rdata    <= '0;
      bus.d_rdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d         <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            arb_busy_o    <= 1'b1;
            bus.pmem_addr <= bus.d_addr;
`ifdef ARB_ROUND_ROBIN_EN
            last_d        <= 1'b1;
`endif
            if (bus.d_write) begin
              state          <= D_WR;
              bus.pmem_write <= 1'b1;
              bus.pmem_wdata <= bus.d_wdata;
            end else begin
              state         <= D_RD;
              bus.pmem_read <= 1'b1;
            end
          end else if (grant_i) begin
            state         <= I_RD;
            arb_busy_o    <= 1'b1;
            bus.pmem_read <= 1'b1;
            bus.pmem_addr <= bus.i_addr;
`ifdef ARB_ROUND_ROBIN_EN
            last_d        <= 1'b0;
`endif
          end
        end

        I_RD, D_RD, D_WR: begin
          if (bus.pmem_resp) begin
            state          <= DONE;
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
            if (state == I_RD) begin
              bus.i_resp  <= 1'b1;
              bus.i_rdata <= bus.pmem_rdata;
            end else begin
              bus.d_resp <= 1'b1;
              if (state == D_RD) bus.d_rdata <= bus.pmem_rdata;
            end
          end
        end

        // Requests are ignored here so a requester still holding its level
        // for one cycle after resp is not granted a second time.
        DONE: begin
          state      <= IDLE;
          arb_busy_o <= 1'b0;
          bus.i_resp <= 1'b0;
          bus.d_resp <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_no_dual_d_req: assert property (@(posedge clk) disable iff (!rst)
    !(bus.d_read && bus.d_write));

endmodule
